// File: rtl/mips_trace_buffer.sv
// Trigger-based instruction trace buffer: circular capture of retiring {pc, instr, alu} with
// a PC trigger, post-trigger window, then in-order readout. Optional macro: TRACE_TIMESTAMP_EN.
module mips_trace_buffer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 4,
    parameter int unsigned TS_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    input  logic [DATA_W-1:0]         pc_in,
    input  logic [DATA_W-1:0]         instr_in,
    input  logic [DATA_W-1:0]         alu_in,
    input  logic                      arm,
    input  logic [DATA_W-1:0]         trig_pc,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_W-1:0]         rd_pc,
    output logic [DATA_W-1:0]         rd_instr,
    output logic [DATA_W-1:0]         rd_alu,
    output logic [1:0]                state,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      wrapped
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]           rd_ts
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || POST_TRIG >= DEPTH || TS_W == 0) begin : g_bad_param
        $fatal(1, "mips_trace_buffer: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle = 2'd0, StArmed = 2'd1, StPost = 2'd2, StFrozen = 2'd3} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   post_q, post_d;
    logic            wrapped_q, wrapped_d;
    logic            capture;
    logic            freeze;

    logic [DATA_W-1:0] mem_pc    [DEPTH];
    logic [DATA_W-1:0] mem_instr [DEPTH];
    logic [DATA_W-1:0] mem_alu   [DEPTH];

    assign capture = valid_in && (state_q == StArmed || state_q == StPost);

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        post_d    = post_q;
        wrapped_d = wrapped_q;
        freeze    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    count_d   = '0;
                    wrapped_d = 1'b0;
                    wr_ptr_d  = '0;
                    post_d    = '0;
                    state_d   = StArmed;
                end
            end
            StArmed: begin
                if (valid_in && pc_in == trig_pc) begin
                    if (POST_TRIG == 0) begin
                        freeze = 1'b1;
                    end else begin
                        post_d  = AW'(POST_TRIG);
                        state_d = StPost;
                    end
                end
            end
            StPost: begin
                if (valid_in) begin
                    post_d = post_q - AW'(1);
                    if (post_q == AW'(1)) begin
                        freeze = 1'b1;
                    end
                end
            end
            StFrozen: begin
                if (count_q == '0) begin
                    state_d = StIdle;
                end else if (rd_ready) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d  = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: ;
        endcase

        if (capture) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q == Full) begin
                wrapped_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end

        // Oldest entry is computed from post-capture values so readout is valid on entry.
        if (freeze) begin
            state_d  = StFrozen;
            rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            post_q    <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            post_q    <= post_d;
            wrapped_q <= wrapped_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            mem_pc[wr_ptr_q]    <= pc_in;
            mem_instr[wr_ptr_q] <= instr_in;
            mem_alu[wr_ptr_q]   <= alu_in;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] mem_ts [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            mem_ts[wr_ptr_q] <= ts_q;
        end
    end

    assign rd_ts = mem_ts[rd_ptr_q];
`endif

    assign rd_valid = (state_q == StFrozen) && (count_q != '0);
    assign rd_pc    = mem_pc[rd_ptr_q];
    assign rd_instr = mem_instr[rd_ptr_q];
    assign rd_alu   = mem_alu[rd_ptr_q];
    assign state    = state_q;
    assign count    = count_q;
    assign wrapped  = wrapped_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed self-checking bench for mips_trace_buffer: one default instance (POST_TRIG=4)
// and one POST_TRIG=0 instance sharing the capture inputs.
module tb_mips_trace_buffer;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_in = 1'b0;
    logic [DW-1:0] pc_in = '0, instr_in = '0, alu_in = '0, trig_pc = '0;
    logic          arm = 1'b0, arm0 = 1'b0;
    logic          rd_ready = 1'b0, rd_ready0 = 1'b0;

    logic          a_rd_valid, z_rd_valid, a_wrapped, z_wrapped;
    logic [DW-1:0] a_rd_pc, a_rd_instr, a_rd_alu, z_rd_pc, z_rd_instr, z_rd_alu;
    logic [1:0]    a_state, z_state;
    logic [4:0]    a_count, z_count;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]   a_rd_ts, z_rd_ts;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_trace_buffer u_dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .instr_in(instr_in),
        .alu_in(alu_in), .arm(arm), .trig_pc(trig_pc), .rd_valid(a_rd_valid),
        .rd_ready(rd_ready), .rd_pc(a_rd_pc), .rd_instr(a_rd_instr), .rd_alu(a_rd_alu),
        .state(a_state), .count(a_count), .wrapped(a_wrapped)
`ifdef TRACE_TIMESTAMP_EN
        , .rd_ts(a_rd_ts)
`endif
    );

    mips_trace_buffer #(.POST_TRIG(0)) u_dut0 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .instr_in(instr_in),
        .alu_in(alu_in), .arm(arm0), .trig_pc(trig_pc), .rd_valid(z_rd_valid),
        .rd_ready(rd_ready0), .rd_pc(z_rd_pc), .rd_instr(z_rd_instr), .rd_alu(z_rd_alu),
        .state(z_state), .count(z_count), .wrapped(z_wrapped)
`ifdef TRACE_TIMESTAMP_EN
        , .rd_ts(z_rd_ts)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [DW-1:0] pc);
        valid_in = 1'b1;
        pc_in    = pc;
        instr_in = pc + 32'h1000;
        alu_in   = pc ^ 32'hFFFF;
        tick();
        valid_in = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] held;
        int n;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        tick();
        check("a_reset_state", 64'(a_state), 64'd0);
        check("a_reset_count", 64'(a_count), 64'd0);
        check("a_reset_rdvalid", 64'(a_rd_valid), 64'd0);
        check("a_reset_wrapped", 64'(a_wrapped), 64'd0);
        check("z_reset_state", 64'(z_state), 64'd0);

        // POST_TRIG=0 instance: three captures, trigger on the third
        trig_pc = 32'h8;
        arm0 = 1'b1; tick(); arm0 = 1'b0;
        check("z_armed", 64'(z_state), 64'd1);
        cap(32'h0); cap(32'h4);
        check("z_armed_count", 64'(z_count), 64'd2);
        cap(32'h8);
        check("z_frozen", 64'(z_state), 64'd3);
        check("z_count3", 64'(z_count), 64'd3);
        check("z_rdvalid", 64'(z_rd_valid), 64'd1);
        check("z_rd0_pc", 64'(z_rd_pc), 64'h0);
        check("z_rd0_instr", 64'(z_rd_instr), 64'h1000);
        check("z_rd0_alu", 64'(z_rd_alu), 64'hFFFF);
        check("a_idle_ignores", 64'(a_count), 64'd0);
        rd_ready0 = 1'b1;
        tick();
        check("z_rd1_pc", 64'(z_rd_pc), 64'h4);
        tick();
        check("z_rd2_pc", 64'(z_rd_pc), 64'h8);
        tick();
        rd_ready0 = 1'b0;
        check("z_back_idle", 64'(z_state), 64'd0);
        check("z_drained", 64'(z_count), 64'd0);
        check("z_rdvalid_off", 64'(z_rd_valid), 64'd0);

        // Default instance: 20 captures, trigger at 0x3C, 4 post entries, wraps
        trig_pc = 32'h3C;
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cap(DW'(4 * i));
            if (i == 15) check("a_post_after_trig", 64'(a_state), 64'd2);
            if (i == 18) check("a_still_post", 64'(a_state), 64'd2);
        end
        check("a_frozen", 64'(a_state), 64'd3);
        check("a_count16", 64'(a_count), 64'd16);
        check("a_wrapped", 64'(a_wrapped), 64'd1);
        check("a_first_pc", 64'(a_rd_pc), 64'h10);

        // valid_in in FROZEN is ignored
        cap(32'h99);
        check("a_frozen_nocap_count", 64'(a_count), 64'd16);
        check("a_frozen_nocap_pc", 64'(a_rd_pc), 64'h10);

        // Stall 5 cycles, then toggle rd_ready
        held = a_rd_pc;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("a_stall_pc", 64'(a_rd_pc), 64'(held));
            check("a_stall_count", 64'(a_count), 64'd16);
        end
        n = 0;
        for (int cyc = 0; cyc < 64 && a_rd_valid; cyc++) begin
            rd_ready = cyc[0];
            #1;
            if (rd_ready) begin
                check("a_read_order", 64'(a_rd_pc), 64'(32'h10 + 4 * n));
                n++;
            end
            tick();
        end
        rd_ready = 1'b0;
        check("a_transfers", 64'(n), 64'd16);
        check("a_drain_idle", 64'(a_state), 64'd0);
        check("a_drain_rdvalid", 64'(a_rd_valid), 64'd0);
        check("a_wrapped_held", 64'(a_wrapped), 64'd1);

        // Reset during POST with count=7, no clock edge
        trig_pc = 32'h10C;
        arm = 1'b1; tick(); arm = 1'b0;
        check("a_rearm_clears", 64'(a_wrapped), 64'd0);
        for (int i = 0; i < 7; i++) cap(DW'(32'h100 + 4 * i));
        check("a_post_state", 64'(a_state), 64'd2);
        check("a_post_count", 64'(a_count), 64'd7);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("a_async_state", 64'(a_state), 64'd0);
        check("a_async_count", 64'(a_count), 64'd0);
        check("a_async_rdvalid", 64'(a_rd_valid), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Clean session; second arm while ARMED ignored; trig match in POST ignored
        trig_pc = 32'h508;
        arm = 1'b1; tick(); arm = 1'b0;
        cap(32'h500);
        arm = 1'b1; cap(32'h504); arm = 1'b0;
        check("a_arm_ignored_state", 64'(a_state), 64'd1);
        check("a_arm_ignored_count", 64'(a_count), 64'd2);
        cap(32'h508);
        check("a_trig2_post", 64'(a_state), 64'd2);
        cap(32'h508); cap(32'h50C); cap(32'h510);
        check("a_no_retrig", 64'(a_state), 64'd2);
        cap(32'h514);
        check("a_frozen2", 64'(a_state), 64'd3);
        check("a_count7", 64'(a_count), 64'd7);
        check("a_wrapped0", 64'(a_wrapped), 64'd0);
        check("a_first_pc2", 64'(a_rd_pc), 64'h500);
        rd_ready = 1'b1;
        tick();
        check("a_second_pc2", 64'(a_rd_pc), 64'h504);
        for (int i = 0; i < 20 && a_rd_valid; i++) tick();
        rd_ready = 1'b0;
        check("a_final_idle", 64'(a_state), 64'd0);
        check("a_final_count", 64'(a_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_trace_buffer.md
MIPS_TRACE_BUFFER -- requirements
Module: mips_trace_buffer

Interface
REQ-001 Parameter DATA_W, default 32: width of the PC, instruction and ALU-result fields.
REQ-002 Parameter DEPTH, default 16: number of trace entries; must be a power of two and at least 4.
REQ-003 Parameter POST_TRIG, default 4: entries captured after the trigger entry; range 0..DEPTH-1.
REQ-004 Parameter TS_W, default 16: timestamp width; used only when TRACE_TIMESTAMP_EN is defined.
REQ-005 clk  in  1  single clock; every state element updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 valid_in  in  1  one instruction retires this cycle.
REQ-008 pc_in, instr_in, alu_in  in  DATA_W each  PC, instruction word and ALU result of the retiring instruction.
REQ-009 arm  in  1  single-cycle request to start a capture session.
REQ-010 trig_pc  in  DATA_W  PC value that fires the trigger.
REQ-011 rd_valid  out  1  a readout entry is presented.
REQ-012 rd_ready  in  1  the consumer accepts the presented entry.
REQ-013 rd_pc, rd_instr, rd_alu  out  DATA_W each  fields of the presented entry.
REQ-014 state  out  2  FSM state: 0=IDLE, 1=ARMED, 2=POST, 3=FROZEN.
REQ-015 count  out  clog2(DEPTH)+1  number of valid entries held.
REQ-016 wrapped  out  1  at least one entry was overwritten during the session.

Function
REQ-017 IDLE: entries are not captured; when arm=1, the block clears count, wrapped and the write pointer, then enters ARMED on the next edge.
REQ-018 ARMED: each cycle with valid_in=1 writes {pc_in, instr_in, alu_in} at the write pointer and advances the pointer modulo DEPTH.
REQ-019 While the buffer holds DEPTH entries, each capture overwrites the oldest entry, count stays at DEPTH, and wrapped is set to 1.
REQ-020 Trigger: in ARMED, valid_in=1 with pc_in==trig_pc captures that entry and moves the FSM to POST with a post counter of POST_TRIG; if POST_TRIG=0, the FSM goes straight to FROZEN.
REQ-021 POST: each capture decrements the post counter; the capture that brings it to 0 moves the FSM to FROZEN on the same edge.
REQ-022 In POST, matches on trig_pc do not re-trigger.
REQ-023 FROZEN: capture stops; valid_in is ignored; the read pointer starts at the oldest entry, which is (write pointer - count) modulo DEPTH.
REQ-024 rd_valid=1 exactly when state=FROZEN and count>0; rd_* are driven combinationally from the entry at the read pointer.
REQ-025 A transfer happens when rd_valid=1 and rd_ready=1: the read pointer advances modulo DEPTH and count decrements; rd_* stay stable while rd_valid=1 and rd_ready=0.
REQ-026 The transfer that brings count to 0 returns the FSM to IDLE; wrapped holds its value until the next arm.
REQ-027 arm is ignored in ARMED, POST and FROZEN.
REQ-028 Entries are read in capture order, oldest first; rd_valid has zero-cycle latency on entering FROZEN.

Reset
REQ-029 Asserting reset immediately forces state=IDLE, count=0, wrapped=0, rd_valid=0, both pointers=0 and the post counter=0, including mid-capture or mid-readout.
REQ-030 Storage array contents are not reset; rd_pc, rd_instr and rd_alu are don't-care while rd_valid=0.

Configuration
REQ-031 With TRACE_TIMESTAMP_EN defined, a free-running TS_W-bit cycle counter (reset to 0, wraps) is stored with each entry and presented on an extra output rd_ts (TS_W bits).
REQ-032 Without TRACE_TIMESTAMP_EN, neither the counter nor the rd_ts port exists, and all other behaviour is identical.

Verification
REQ-033 Reset, arm, 3 captures at PC 0,4,8, trig_pc=8, POST_TRIG=0 -> FROZEN, count=3, readout PC 0,4,8, then IDLE.
REQ-034 DEPTH=16, POST_TRIG=4, 20 captures at PC 0x00..0x4C, trig_pc=0x3C -> FROZEN after PC 0x4C, count=16, wrapped=1, first read PC=0x10.
REQ-035 FROZEN with rd_ready held 0 for 5 cycles, then toggled each cycle -> rd_* stable while stalled, no entry lost or duplicated, 16 transfers total.
REQ-036 Reset asserted in POST with count=7 -> state=IDLE, count=0 and rd_valid=0 immediately without a clock edge; a later arm starts a clean session.
REQ-037 valid_in=1 in FROZEN and a second arm in ARMED -> count unchanged and session unaffected.
REQ-038 With TRACE_TIMESTAMP_EN, captures on cycles 10, 11 and 15 after reset -> rd_ts=10, 11, 15.
